// File: rtl/lbp_pkg.sv
// Shared constants and state encoding for the LBP histogram slice.
// The frame geometry is kept here so every stage agrees on the interior pixel count.
package lbp_pkg;

    localparam int IMG_W        = 128;
    localparam int IMG_H        = 128;
    localparam int NBINS        = 256;
    localparam int CNT_W        = 14;
    localparam int INTERIOR_PIX = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        DUMP,
        DONE
    } state_t;

endpackage

// File: rtl/hist_ram.sv
// Bin storage: one synchronous read port and one write port, 1-cycle read latency.
// A read and a write to the same address on the same edge return the old word.
module hist_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 14
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lbp_histogram.sv
// Accumulates a 256-bin histogram of LBP codes with a read-modify-write pipeline,
// then streams every bin out over a valid/ready port once the frame is finished.
module lbp_histogram #(
    parameter int CNT_W = lbp_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             drop_err
);

    import lbp_pkg::*;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_s1_valid;
    logic [7:0]         r_s1_bin;
    logic               r_s1_tag;
    logic               r_s2_valid;
    logic [7:0]         r_s2_bin;
    logic [CNT_W-1:0]   r_s2_data;

    logic [NBINS-1:0]   r_tag;
    logic [7:0]         r_bin;
    logic               r_hist_valid;
    logic               r_dump_tag;
    logic               r_drop_err;

    logic               w_accept;
    logic               w_dump_read;
    logic               w_handshake;
    logic               w_ram_re;
    logic [7:0]         w_ram_raddr;
    logic [CNT_W-1:0]   w_ram_q;
    logic               w_fwd;
    logic [CNT_W-1:0]   w_old;
    logic [CNT_W-1:0]   w_new;
    logic               w_sat;

    assign w_accept    = (r_state == ACCUM) && lbp_valid;
    assign w_dump_read = (r_state == DUMP) && !r_hist_valid;
    assign w_handshake = r_hist_valid && hist_ready;

    always_comb begin
        w_ram_re    = w_accept || w_dump_read;
        w_ram_raddr = (r_state == ACCUM) ? lbp_data : r_bin;
    end

    hist_ram #(
        .DEPTH (NBINS),
        .AW    (8),
        .DW    (CNT_W)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q),
        .i_we    (r_s1_valid),
        .i_waddr (r_s1_bin),
        .i_wdata (w_new)
    );

    // The RAM returns stale data when the previous cycle wrote the same bin, so
    // that write is replayed from stage 2; untagged bins read as zero.
    always_comb begin
        w_fwd = r_s2_valid && (r_s2_bin == r_s1_bin);
        w_old = w_fwd ? r_s2_data : (r_s1_tag ? w_ram_q : '0);
        w_sat = &w_old;
        w_new = w_sat ? w_old : w_old + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (finish) w_state_next = DRAIN;
            DRAIN:   if (!r_s1_valid) w_state_next = DUMP;
            DUMP:    if (w_handshake && (r_bin == 8'hFF)) w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_s1_tag   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_data  <= '0;
            r_tag      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_bin   <= lbp_data;
            r_s1_tag   <= r_tag[lbp_data];
            r_s2_valid <= r_s1_valid;
            r_s2_bin   <= r_s1_bin;
            r_s2_data  <= w_new;
            if (r_s1_valid) begin
                r_tag[r_s1_bin] <= 1'b1;
            end
            if ((lbp_valid && (r_state != ACCUM)) || (r_s1_valid && w_sat)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Each bin costs one read cycle with valid low, then holds until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin        <= '0;
            r_hist_valid <= 1'b0;
            r_dump_tag   <= 1'b0;
        end else if (r_state == DRAIN) begin
            r_bin <= '0;
        end else if (w_dump_read) begin
            r_hist_valid <= 1'b1;
            r_dump_tag   <= r_tag[r_bin];
        end else if (w_handshake) begin
            r_hist_valid <= 1'b0;
            if (r_bin != 8'hFF) begin
                r_bin <= r_bin + 8'd1;
            end
        end
    end

    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_bin;
    assign hist_count = (r_hist_valid && r_dump_tag) ? w_ram_q : '0;
    assign hist_done  = (r_state == DONE);
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_lbp_histogram.sv
// Self-checking bench for lbp_histogram: random and directed code streams are
// compared against a plain per-bin count array after the histogram is dumped.
module tb_lbp_histogram;

    localparam int CNT_W = 14;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             lbp_valid;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic             hist_done;
    logic             drop_err;

    int n_checks = 0;
    int n_pass   = 0;
    int model [256];
    int got   [256];

    lbp_histogram #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int b = 0; b < 256; b++) begin
            model[b] = 0;
            got[b]   = -1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        lbp_valid  = 1'b0;
        lbp_data   = 8'h00;
        finish     = 1'b0;
        hist_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic send_code(input logic [7:0] code);
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_data  = code;
        model[code]++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            lbp_valid = 1'b0;
        end
    endtask

    // mode 0: always ready, mode 1: 3 cycles low / 1 high, otherwise random
    task automatic collect_dump(input int mode, output int tmo, output int order_err,
                                output int stall_err, output int early_done);
        int   n;
        logic rdy;
        logic prev_stall;
        logic [7:0] pb;
        logic [CNT_W-1:0] pc;
        n = 0; tmo = 1; order_err = 0; stall_err = 0; early_done = 0;
        prev_stall = 1'b0; pb = '0; pc = '0;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            @(negedge clk);
            lbp_valid = 1'b0;
            if (prev_stall && (hist_valid !== 1'b1 || hist_bin !== pb || hist_count !== pc))
                stall_err++;
            if (hist_done === 1'b1 && n < 256) early_done++;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ((cyc % 4) == 3);
            else rdy = 1'($urandom_range(0, 1));
            hist_ready = rdy;
            if (hist_valid === 1'b1 && rdy) begin
                if (hist_bin !== n[7:0]) order_err++;
                got[n] = int'(hist_count);
                n++;
            end
            prev_stall = (hist_valid === 1'b1) && !rdy;
            pb = hist_bin;
            pc = hist_count;
            if (n == 256) begin
                tmo = 0;
                break;
            end
        end
        @(negedge clk);
        hist_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lbp_valid = 1'b0; lbp_data = 8'h00; finish = 1'b0; hist_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (hist_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", hist_valid); else n_pass++;
        n_checks++; if (hist_bin !== 8'd0) $display("[TB] FAIL reset_bin: got %0d expected 0", hist_bin); else n_pass++;
        n_checks++; if (hist_count !== '0) $display("[TB] FAIL reset_count: got %0d expected 0", hist_count); else n_pass++;
        n_checks++; if (hist_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", hist_done); else n_pass++;
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL reset_drop: got %b expected 0", drop_err); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_bin();
        int tmo, oe, se, ed, sum;
        do_reset();
        for (int i = 0; i < lbp_pkg::INTERIOR_PIX; i++) send_code(8'hFF);
        finish = 1'b1;
        collect_dump(0, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL single_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (oe != 0) $display("[TB] FAIL single_order: got %0d errors expected 0", oe); else n_pass++;
        n_checks++; if (ed != 0) $display("[TB] FAIL single_early_done: got %0d expected 0", ed); else n_pass++;
        n_checks++; if (got[255] != 15876) $display("[TB] FAIL single_bin255: got %0d expected 15876", got[255]); else n_pass++;
        sum = 0;
        for (int b = 0; b < 256; b++) begin
            sum += got[b];
            n_checks++;
            if (got[b] != (model[b] > SAT ? SAT : model[b]))
                $display("[TB] FAIL single_bin%0d: got %0d expected %0d", b, got[b], model[b]);
            else n_pass++;
        end
        n_checks++; if (sum != lbp_pkg::INTERIOR_PIX) $display("[TB] FAIL single_sum: got %0d expected %0d", sum, lbp_pkg::INTERIOR_PIX); else n_pass++;
        n_checks++; if (hist_done !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", hist_done); else n_pass++;
        n_checks++; if (hist_valid !== 1'b0) $display("[TB] FAIL single_valid_after: got %b expected 0", hist_valid); else n_pass++;
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL single_drop: got %b expected 0", drop_err); else n_pass++;
    endtask

    task automatic test_forwarding();
        int tmo, oe, se, ed;
        do_reset();
        for (int i = 0; i < 30; i++) send_code((i % 3 == 2) ? 8'h06 : 8'h05);
        finish = 1'b1;
        collect_dump(0, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL fwd_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (got[5] != 20) $display("[TB] FAIL fwd_bin5: got %0d expected 20", got[5]); else n_pass++;
        n_checks++; if (got[6] != 10) $display("[TB] FAIL fwd_bin6: got %0d expected 10", got[6]); else n_pass++;
        for (int b = 0; b < 256; b++) begin
            n_checks++;
            if (got[b] != model[b]) $display("[TB] FAIL fwd_bin%0d: got %0d expected %0d", b, got[b], model[b]);
            else n_pass++;
        end
    endtask

    task automatic test_cadence();
        int tmo, oe, se, ed;
        do_reset();
        for (int i = 0; i < 1030; i++) begin
            send_code(8'(i % 256));
            idle(9);
        end
        finish = 1'b1;
        collect_dump(2, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL cad_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (oe != 0) $display("[TB] FAIL cad_order: got %0d errors expected 0", oe); else n_pass++;
        n_checks++; if (se != 0) $display("[TB] FAIL cad_stall: got %0d errors expected 0", se); else n_pass++;
        for (int b = 0; b < 256; b++) begin
            n_checks++;
            if (got[b] != model[b]) $display("[TB] FAIL cad_bin%0d: got %0d expected %0d", b, got[b], model[b]);
            else n_pass++;
        end
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL cad_drop: got %b expected 0", drop_err); else n_pass++;
    endtask

    task automatic test_stall_random();
        int tmo, oe, se, ed;
        logic [7:0] code;
        do_reset();
        code = 8'($urandom_range(0, 255));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) code = 8'($urandom_range(0, 255));
            send_code(code);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        finish = 1'b1;
        collect_dump(1, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL stall_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (oe != 0) $display("[TB] FAIL stall_order: got %0d errors expected 0", oe); else n_pass++;
        n_checks++; if (se != 0) $display("[TB] FAIL stall_hold: got %0d errors expected 0", se); else n_pass++;
        n_checks++; if (ed != 0) $display("[TB] FAIL stall_early_done: got %0d expected 0", ed); else n_pass++;
        for (int b = 0; b < 256; b++) begin
            n_checks++;
            if (got[b] != model[b]) $display("[TB] FAIL stall_bin%0d: got %0d expected %0d", b, got[b], model[b]);
            else n_pass++;
        end
        n_checks++; if (hist_done !== 1'b1) $display("[TB] FAIL stall_done: got %b expected 1", hist_done); else n_pass++;
    endtask

    task automatic test_drop();
        int tmo, oe, se, ed;
        do_reset();
        send_code(8'h10); send_code(8'h10); send_code(8'h10); send_code(8'h11);
        finish = 1'b1;
        @(negedge clk);
        lbp_valid = 1'b0;
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL drop_before: got %b expected 0", drop_err); else n_pass++;
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_data  = 8'h10;
        collect_dump(0, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL drop_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (drop_err !== 1'b1) $display("[TB] FAIL drop_flag: got %b expected 1", drop_err); else n_pass++;
        n_checks++; if (got[16] != 3) $display("[TB] FAIL drop_bin16: got %0d expected 3", got[16]); else n_pass++;
        n_checks++; if (got[17] != 1) $display("[TB] FAIL drop_bin17: got %0d expected 1", got[17]); else n_pass++;
    endtask

    task automatic test_saturation();
        int tmo, oe, se, ed;
        do_reset();
        for (int i = 0; i < SAT; i++) send_code(8'h3C);
        idle(3);
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL sat_early: got %b expected 0", drop_err); else n_pass++;
        send_code(8'h3C); send_code(8'h3C);
        idle(3);
        n_checks++; if (drop_err !== 1'b1) $display("[TB] FAIL sat_flag: got %b expected 1", drop_err); else n_pass++;
        finish = 1'b1;
        collect_dump(0, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL sat_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (got[60] != (model[60] > SAT ? SAT : model[60]))
            $display("[TB] FAIL sat_bin60: got %0d expected %0d", got[60], SAT); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        int tmo, oe, se, ed, found;
        do_reset();
        for (int i = 0; i < 500; i++) send_code((i % 5 == 0) ? 8'h07 : 8'($urandom_range(0, 255)));
        finish = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            lbp_valid  = (cyc == 5);
            lbp_data   = 8'h10;
            hist_ready = 1'b1;
            if (hist_valid === 1'b1 && hist_bin === 8'd100) begin
                found = 1;
                break;
            end
        end
        n_checks++; if (found != 1) $display("[TB] FAIL mid_reach_bin100: got %0d expected 1", found); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (hist_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", hist_valid); else n_pass++;
        n_checks++; if (hist_bin !== 8'd0) $display("[TB] FAIL mid_bin: got %0d expected 0", hist_bin); else n_pass++;
        n_checks++; if (hist_count !== '0) $display("[TB] FAIL mid_count: got %0d expected 0", hist_count); else n_pass++;
        n_checks++; if (drop_err !== 1'b0) $display("[TB] FAIL mid_drop: got %b expected 0", drop_err); else n_pass++;
        lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
        send_code(8'h07); send_code(8'h07); send_code(8'h07);
        finish = 1'b1;
        collect_dump(0, tmo, oe, se, ed);
        n_checks++; if (tmo != 0) $display("[TB] FAIL mid_timeout: got %0d expected 0", tmo); else n_pass++;
        n_checks++; if (got[7] != 3) $display("[TB] FAIL mid_bin7: got %0d expected 3", got[7]); else n_pass++;
        for (int b = 0; b < 256; b++) begin
            n_checks++;
            if (got[b] != model[b]) $display("[TB] FAIL mid_bin%0d: got %0d expected %0d", b, got[b], model[b]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_forwarding();
        test_cadence();
        test_stall_random();
        test_drop();
        test_saturation();
        test_reset_mid_dump();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
